// File: rtl/fsm_seq_timed.sv
// fsm_seq_timed: five-state Moore control sequencer (S0..S4) with registered
// outputs, a minimum-dwell qualifier, a self-loop timeout on S1/S3, an
// enable/freeze input and one-cycle done/timeout status pulses.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   en            1 = advance, 0 = freeze state/counter/outputs (pulses drop)
//   state_inputs  external control condition (IN_W bits)
//   comb_outputs  registered control code of the current state (OUT_W bits)
//   state_code    current state, S0=0 .. S4=4
//   done          pulse on the first S0 cycle after S4
//   timeout       pulse on the first S0 cycle after a forced self-loop exit
module fsm_seq_timed #(
  parameter int unsigned IN_W    = 2,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DWELL   = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [OUT_W-1:0] OUT_S0 = OUT_W'(5),
  parameter logic [OUT_W-1:0] OUT_S1 = OUT_W'(8),
  parameter logic [OUT_W-1:0] OUT_S2 = OUT_W'(12),
  parameter logic [OUT_W-1:0] OUT_S3 = OUT_W'(14),
  parameter logic [OUT_W-1:0] OUT_S4 = OUT_W'(9),
  parameter logic [IN_W-1:0]  M0     = IN_W'(0),
  parameter logic [IN_W-1:0]  M1     = IN_W'(1),
  parameter logic [IN_W-1:0]  M2     = IN_W'(2),
  parameter logic [IN_W-1:0]  M3     = IN_W'(3)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IN_W-1:0]  state_inputs,
  output logic [OUT_W-1:0] comb_outputs,
  output logic [2:0]       state_code,
  output logic             done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam bit               TO_ON      = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST    = TO_ON ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [OUT_W-1:0] out_n;
  logic             done_n, timeout_n;
  logic             qual, self_loop, forced;

  // Control code presented while in a given state.
  function automatic logic [OUT_W-1:0] code_of(input state_t s);
    case (s)
      S0:      code_of = OUT_S0;
      S1:      code_of = OUT_S1;
      S2:      code_of = OUT_S2;
      S3:      code_of = OUT_S3;
      S4:      code_of = OUT_S4;
      default: code_of = OUT_S0;
    endcase
  endfunction

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S0;
      dwell_cnt    <= '0;
      comb_outputs <= OUT_S0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      dwell_cnt    <= dwell_cnt_n;
      comb_outputs <= out_n;
      done         <= done_n;
      timeout      <= timeout_n;
    end
  end

  assign state_code = 3'(state);

  // Next state, counter and outputs.
  always_comb begin
    state_n     = state;
    dwell_cnt_n = dwell_cnt;
    out_n       = comb_outputs;
    done_n      = 1'b0;
    timeout_n   = 1'b0;
    qual        = (dwell_cnt >= DWELL_LAST);
    self_loop   = 1'b0;
    forced      = 1'b0;

    if (en) begin
      case (state)
        S1:      self_loop = (state_inputs == M1);
        S3:      self_loop = (state_inputs == M3);
        default: self_loop = 1'b0;
      endcase
      // Timeout overrides a self-loop regardless of the dwell qualifier.
      forced = TO_ON && self_loop && (dwell_cnt == TO_LAST);

      if (forced) begin
        state_n = S0;
      end else if (qual) begin
        case (state)
          S0:      state_n = (state_inputs == M0) ? S0 : S1;
          S1:      state_n = (state_inputs == M1) ? S1 : S2;
          S2:      state_n = (state_inputs == M2) ? S4 : S3;
          S3:      state_n = (state_inputs == M3) ? S3 : S4;
          S4:      state_n = S0;
          default: state_n = S0;
        endcase
      end

      if (state_n != state) begin
        dwell_cnt_n = '0;
      end else if (dwell_cnt != '1) begin
        dwell_cnt_n = dwell_cnt + CNT_W'(1);
      end

      out_n     = code_of(state_n);
      timeout_n = forced;
      done_n    = !forced && (state == S4) && (state_n == S0);
    end
  end

endmodule
